xfer_sequencer: RTL and testbench

- Sequences a word-by-word transfer from a local read buffer to a partner, using a four-phase req/ack handshake.
- Transfers are gated by the partner's ReadyForTransferIn level and paced by a tick pulse derived from the clock divider.
- Sits between the board top level (SW/KEY inputs, LEDR/HEX status) and the buffer/partner datapath.
- Provides the busy, done, error and word-count status that the top level displays.

---
 rtl/xfer_pkg.sv | 31 +++
 rtl/xfer_sequencer_if.sv | 34 +++
 rtl/xfer_sequencer_tick_timeout.sv | 48 ++++
 rtl/xfer_sequencer.sv | 166 ++++++++++++++++
 tb/tb_xfer_sequencer.sv | 373 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/xfer_pkg.sv
// ---------------------------------------------------------------------------
// xfer_pkg
// Shared definitions for the transfer sequencer:
//   - default DATA_W / DEPTH / TIMEOUT values
//   - 3-bit state encoding used by the sequencer FSM
//   - helper telling whether a state counts as "transfer in progress"
// ---------------------------------------------------------------------------
package xfer_pkg;

    localparam int DATA_W_DEF  = 8;
    localparam int DEPTH_DEF   = 8;
    localparam int TIMEOUT_DEF = 15;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT_RDY = 3'd1,
        FETCH    = 3'd2,
        LOAD     = 3'd3,
        REQ      = 3'd4,
        REL      = 3'd5,
        DONE     = 3'd6,
        ERR      = 3'd7
    } xfer_state_e;

    // Every state between launch and completion/error keeps busy high.
    function automatic logic is_busy_state(xfer_state_e s);
        return (s == WAIT_RDY) || (s == FETCH) || (s == LOAD) ||
               (s == REQ)      || (s == REL);
    endfunction

endpackage

// File: rtl/xfer_sequencer_if.sv
// ---------------------------------------------------------------------------
// xfer_sequencer_if
// Buffer-read and partner-handshake signals of the transfer sequencer.
//   ready_in : partner ReadyForTransferIn level
//   ack_in   : partner four-phase acknowledge
//   buf_data : buffer read data, valid one cycle after buf_addr
//   buf_addr : buffer read address
//   data_out : word presented to the partner
//   req_out  : four-phase request to the partner
// master = sequencer side, slave = buffer/partner side.
// ---------------------------------------------------------------------------
interface xfer_sequencer_if
    import xfer_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = 3
);
    logic              ready_in;
    logic              ack_in;
    logic [DATA_W-1:0] buf_data;
    logic [ADDR_W-1:0] buf_addr;
    logic [DATA_W-1:0] data_out;
    logic              req_out;

    modport master (
        input  ready_in, ack_in, buf_data,
        output buf_addr, data_out, req_out
    );

    modport slave (
        output ready_in, ack_in, buf_data,
        input  buf_addr, data_out, req_out
    );
endinterface

// File: rtl/xfer_sequencer_tick_timeout.sv
// ---------------------------------------------------------------------------
// tick_timeout
// Counts tick pulses since the last clear. expired pulses on the tick that
// would be the TIMEOUT-th one; a clear in the same cycle suppresses it so
// that an ack edge always beats the terminal tick.
// Ports:
//   clk, rst (async active-low)
//   clr     : restart counting from zero
//   tick    : qualified pacing pulse (already gated by the caller)
//   expired : terminal tick seen this cycle
// ---------------------------------------------------------------------------
module tick_timeout
    import xfer_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic tick,
    output logic expired
);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] MAXV = CW'(TIMEOUT);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (tick && (cnt_q != MAXV)) begin
            // saturate so a stray extra tick can never wrap back to zero
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign expired = tick & ~clr & (cnt_q == LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/xfer_sequencer.sv
// ---------------------------------------------------------------------------
// xfer_sequencer
// Moves DEPTH words from a local read buffer to a partner, one four-phase
// req/ack handshake per word. Each word waits for a tick with ready_in high,
// then takes one cycle to settle the buffer address and one to load data_out
// before req_out rises. A tick-based timeout guards both ack edges.
// Ports:
//   clk, rst (async active-low), tick, start (rising edge launches)
//   bus        : xfer_sequencer_if.master (buffer read + partner handshake)
//   busy       : transfer in progress
//   done       : sticky, last transfer completed
//   err        : sticky, last transfer timed out
//   word_count : words acknowledged in current/last transfer
// All outputs are registered, so an asserted rst clears them immediately.
// ---------------------------------------------------------------------------
module xfer_sequencer
    import xfer_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int DEPTH   = DEPTH_DEF,
    parameter int ADDR_W  = $clog2(DEPTH),
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick,
    input  logic              start,
    xfer_sequencer_if.master  bus,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   word_count
);
    localparam logic [ADDR_W:0] WC_FULL = (ADDR_W + 1)'(DEPTH);

    xfer_state_e       state_q, state_d;
    logic              start_q;
    logic [ADDR_W-1:0] buf_addr_q, buf_addr_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic              req_q, req_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [ADDR_W:0]   wc_q, wc_d;

    logic launch;
    logic tmr_clr;
    logic tmr_tick;
    logic tmr_expired;

    // Only a fresh rising edge of start counts; holding it high does nothing.
    assign launch = start & ~start_q;

    // The timeout only advances while a handshake edge is outstanding.
    assign tmr_tick = tick & ((state_q == REQ) || (state_q == REL));

    tick_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clr     (tmr_clr),
        .tick    (tmr_tick),
        .expired (tmr_expired)
    );

    always_comb begin
        state_d    = state_q;
        buf_addr_d = buf_addr_q;
        data_out_d = data_out_q;
        done_d     = done_q;
        err_d      = err_q;
        wc_d       = wc_q;
        tmr_clr    = 1'b0;

        case (state_q)
            IDLE, DONE, ERR: begin
                if (launch) begin
                    state_d    = WAIT_RDY;
                    done_d     = 1'b0;
                    err_d      = 1'b0;
                    wc_d       = '0;
                    buf_addr_d = '0;
                end
            end
            WAIT_RDY: begin
                if (tick && bus.ready_in) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                // buf_addr has been stable for a full cycle after this one
                state_d = LOAD;
            end
            LOAD: begin
                data_out_d = bus.buf_data;
                state_d    = REQ;
                tmr_clr    = 1'b1;
            end
            REQ: begin
                // ack is checked first so it wins over a coincident terminal tick
                if (bus.ack_in) begin
                    state_d = REL;
                    tmr_clr = 1'b1;
                end else if (tmr_expired) begin
                    state_d = ERR;
                    err_d   = 1'b1;
                end
            end
            REL: begin
                if (!bus.ack_in) begin
                    wc_d = wc_q + 1'b1;
                    if ((wc_q + 1'b1) == WC_FULL) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        buf_addr_d = buf_addr_q + 1'b1;
                        state_d    = WAIT_RDY;
                    end
                end else if (tmr_expired) begin
                    state_d = ERR;
                    err_d   = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Registered outputs follow the state being entered.
        busy_d = is_busy_state(state_d);
        req_d  = (state_d == REQ);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            start_q    <= 1'b0;
            buf_addr_q <= '0;
            data_out_q <= '0;
            req_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            wc_q       <= '0;
        end else begin
            state_q    <= state_d;
            start_q    <= start;
            buf_addr_q <= buf_addr_d;
            data_out_q <= data_out_d;
            req_q      <= req_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            wc_q       <= wc_d;
        end
    end

    assign bus.buf_addr = buf_addr_q;
    assign bus.data_out = data_out_q;
    assign bus.req_out  = req_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign err          = err_q;
    assign word_count   = wc_q;
endmodule

// File: tb/tb_xfer_sequencer.sv
// ---------------------------------------------------------------------------
// tb_xfer_sequencer
// Drives the sequencer with directed scenarios and randomized transfers,
// playing the buffer and the partner. A transaction-level model tracks what
// the outputs must be; a compare process checks them every cycle.
// ---------------------------------------------------------------------------
module tb_xfer_sequencer;
    import xfer_pkg::*;

    localparam int DATA_W  = 8;
    localparam int DEPTH   = 8;
    localparam int ADDR_W  = 3;
    localparam int TIMEOUT = 15;

    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic tick  = 1'b0;
    logic start = 1'b0;
    logic busy, done, err;
    logic [ADDR_W:0] word_count;

    xfer_sequencer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    xfer_sequencer #(
        .DATA_W  (DATA_W),
        .DEPTH   (DEPTH),
        .ADDR_W  (ADDR_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tick       (tick),
        .start      (start),
        .bus        (bus.master),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- buffer: synchronous read RAM ----------------
    logic [DATA_W-1:0] mem [DEPTH];
    always @(posedge clk) bus.buf_data <= mem[bus.buf_addr];

    // ---------------- stimulus knobs ----------------
    int tick_mode    = 0;   // 0 every cycle, 1 random, 2 manual, 3 every third cycle
    bit ready_rand   = 0;
    bit partner_auto = 1;
    bit never_ack    = 0;
    int ack_dly      = 2;
    int rel_dly      = 2;
    int p_cnt        = 0;
    int cyc          = 0;

    // Tick, ready and partner behaviour, all changed on the falling edge.
    initial begin
        bus.ready_in = 1'b0;
        bus.ack_in   = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            case (tick_mode)
                0: tick = 1'b1;
                1: tick = ($urandom_range(0, 2) == 0);
                3: tick = ((cyc % 3) == 0);
                default: ;
            endcase
            if (ready_rand) bus.ready_in = ($urandom_range(0, 3) != 0);
            if (partner_auto) begin
                if (!bus.ack_in) begin
                    if (bus.req_out && !never_ack) begin
                        if (p_cnt >= ack_dly) begin
                            bus.ack_in = 1'b1;
                            p_cnt = 0;
                        end else p_cnt++;
                    end else p_cnt = 0;
                end else if (!bus.req_out) begin
                    if (p_cnt >= rel_dly) begin
                        bus.ack_in = 1'b0;
                        p_cnt = 0;
                    end else p_cnt++;
                end
            end
        end
    end

    // ---------------- transaction-level model ----------------
    // Tracks the transfer narrative: waiting for a go-ahead, a fixed 2-edge
    // preparation delay, the request phase, the release phase.
    bit m_busy = 0, m_done = 0, m_err = 0, m_req = 0, m_rel = 0, m_wait = 0, m_sp = 0;
    int m_pipe = 0, m_ticks = 0, m_wc = 0;

    initial begin
        bit launch;
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                m_busy = 0; m_done = 0; m_err = 0; m_req = 0; m_rel = 0;
                m_wait = 0; m_sp = 0; m_pipe = 0; m_ticks = 0; m_wc = 0;
            end else begin
                launch = start && !m_sp;
                m_sp   = start;
                if (!m_busy) begin
                    if (launch) begin
                        m_busy = 1; m_done = 0; m_err = 0; m_wc = 0; m_wait = 1;
                    end
                end else if (m_wait) begin
                    if (tick && bus.ready_in) begin
                        m_wait = 0;
                        m_pipe = 2;
                    end
                end else if (m_pipe > 0) begin
                    m_pipe--;
                    if (m_pipe == 0) begin
                        m_req = 1;
                        m_ticks = 0;
                    end
                end else if (m_req) begin
                    if (bus.ack_in) begin
                        m_req = 0; m_rel = 1; m_ticks = 0;
                    end else if (tick) begin
                        m_ticks++;
                        if (m_ticks == TIMEOUT) begin
                            m_req = 0; m_err = 1; m_busy = 0;
                        end
                    end
                end else if (m_rel) begin
                    if (!bus.ack_in) begin
                        m_rel = 0;
                        m_wc++;
                        if (m_wc == DEPTH) begin
                            m_done = 1; m_busy = 0;
                        end else m_wait = 1;
                    end else if (tick) begin
                        m_ticks++;
                        if (m_ticks == TIMEOUT) begin
                            m_rel = 0; m_err = 1; m_busy = 0;
                        end
                    end
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("busy", 32'(busy), 32'(m_busy));
                chk("done", 32'(done), 32'(m_done));
                chk("err", 32'(err), 32'(m_err));
                chk("req_out", 32'(bus.req_out), 32'(m_req));
                chk("word_count", 32'(word_count), 32'(m_wc));
                chk("buf_addr", 32'(bus.buf_addr), (m_wc == DEPTH) ? 32'(DEPTH - 1) : 32'(m_wc));
                if (m_req || m_rel)
                    chk("data_out", 32'(bus.data_out), 32'(mem[m_wc]));
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_req(logic lvl, int budget, string nm);
        int c = 0;
        while (bus.req_out !== lvl && c < budget) begin
            step();
            c++;
        end
        chk(nm, 32'(bus.req_out), 32'(lvl));
    endtask

    task automatic wait_idle(int budget, string nm);
        int c = 0;
        while (busy !== 1'b0 && c < budget) begin
            step();
            c++;
        end
        chk(nm, 32'(busy), 32'd0);
    endtask

    task automatic wait_wc(int val, int budget, string nm);
        int c = 0;
        while (32'(word_count) != val && c < budget) begin
            step();
            c++;
        end
        chk(nm, 32'(word_count), 32'(val));
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int n;
        bit found;
        for (int i = 0; i < DEPTH; i++) mem[i] = 8'(8'h11 * (i + 1));

        #1 rst = 1'b0;
        step();
        step();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_req", 32'(bus.req_out), 32'd0);
        chk("rst_wc", 32'(word_count), 32'd0);
        chk("rst_addr", 32'(bus.buf_addr), 32'd0);
        chk("rst_data", 32'(bus.data_out), 32'd0);
        rst = 1'b1;
        step();

        // full transfer, ack 2 cycles after req, release 2 cycles after drop
        bus.ready_in = 1'b1;
        tick_mode = 0; ack_dly = 2; rel_dly = 2;
        pulse_start();
        for (int i = 0; i < DEPTH; i++) begin
            wait_req(1'b1, 100, "full_req_hi");
            chk("full_data", 32'(bus.data_out), 32'(8'h11 * (i + 1)));
            wait_req(1'b0, 100, "full_req_lo");
        end
        wait_idle(100, "full_idle");
        chk("full_wc", 32'(word_count), 32'd8);
        chk("full_done", 32'(done), 32'd1);
        chk("full_err", 32'(err), 32'd0);

        // ready drops after word 3 is acknowledged
        pulse_start();
        wait_wc(3, 300, "rdy_wc3");
        bus.ready_in = 1'b0;
        repeat (10) step();
        chk("rdy_hold_wc", 32'(word_count), 32'd3);
        chk("rdy_hold_req", 32'(bus.req_out), 32'd0);
        chk("rdy_hold_busy", 32'(busy), 32'd1);
        bus.ready_in = 1'b1;
        wait_req(1'b1, 50, "rdy_resume_req");
        chk("rdy_word4", 32'(bus.data_out), 32'h44);
        wait_idle(300, "rdy_idle");
        chk("rdy_done", 32'(done), 32'd1);

        // asynchronous reset in the middle of a request
        ack_dly = 6;
        pulse_start();
        found = 0;
        for (int c = 0; c < 300; c++) begin
            if (word_count == 2 && bus.req_out) begin
                found = 1;
                break;
            end
            step();
        end
        chk("arst_found", 32'(found), 32'd1);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("arst_req", 32'(bus.req_out), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_wc", 32'(word_count), 32'd0);
        #1 rst = 1'b1;
        repeat (4) step();
        chk("arst_idle", 32'(busy), 32'd0);
        ack_dly = 2;

        // start held high plus an extra pulse mid-transfer
        start = 1'b1;
        wait_wc(4, 300, "hold_wc4");
        start = 1'b0;
        step();
        start = 1'b1;
        wait_idle(300, "hold_idle");
        repeat (20) step();
        chk("hold_busy", 32'(busy), 32'd0);
        chk("hold_wc", 32'(word_count), 32'd8);
        chk("hold_done", 32'(done), 32'd1);
        start = 1'b0;
        step();

        // partner never acks: error on the 15th tick during req
        never_ack = 1;
        tick_mode = 3;
        pulse_start();
        wait_req(1'b1, 100, "to_req");
        n = 0;
        found = 0;
        for (int c = 0; c < 400; c++) begin
            if (bus.req_out && tick) n++;
            step();
            if (err) begin
                found = 1;
                break;
            end
        end
        chk("to_seen", 32'(found), 32'd1);
        chk("to_ticks", 32'(n), 32'd15);
        chk("to_req_lo", 32'(bus.req_out), 32'd0);
        chk("to_wc", 32'(word_count), 32'd0);
        never_ack = 0;
        tick_mode = 0;
        pulse_start();
        chk("to_restart_err", 32'(err), 32'd0);
        chk("to_restart_addr", 32'(bus.buf_addr), 32'd0);
        chk("to_restart_busy", 32'(busy), 32'd1);
        wait_idle(300, "to_restart_idle");
        chk("to_restart_done", 32'(done), 32'd1);

        // ack arrives together with the terminal tick
        partner_auto = 0;
        bus.ack_in = 1'b0;
        pulse_start();
        wait_req(1'b1, 100, "race_req");
        tick_mode = 2;
        for (int k = 0; k < TIMEOUT - 1; k++) begin
            tick = 1'b1;
            step();
            tick = 1'b0;
            step();
        end
        tick = 1'b1;
        bus.ack_in = 1'b1;
        step();
        tick = 1'b0;
        chk("race_err", 32'(err), 32'd0);
        chk("race_req_lo", 32'(bus.req_out), 32'd0);
        chk("race_busy", 32'(busy), 32'd1);
        p_cnt = 0; ack_dly = 1; rel_dly = 1;
        partner_auto = 1;
        tick_mode = 0;
        wait_idle(300, "race_idle");
        chk("race_done", 32'(done), 32'd1);
        chk("race_wc", 32'(word_count), 32'd8);

        // randomized transfers
        ready_rand = 1;
        tick_mode = 1;
        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < DEPTH; i++) mem[i] = 8'($urandom);
            ack_dly = $urandom_range(0, 3);
            rel_dly = $urandom_range(0, 3);
            never_ack = ($urandom_range(0, 5) == 0);
            pulse_start();
            for (int c = 0; c < 3000 && busy; c++) begin
                start = ($urandom_range(0, 39) == 0);
                step();
            end
            start = 1'b0;
            wait_idle(10, "rand_idle");
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
